// File: rtl/canny_frame_sequencer.sv
// Frame-level sequencer for a fixed-latency Canny pixel pipeline: latches geometry,
// requests the output control packet, then paces reads, pipeline advance and writes.
module canny_frame_sequencer #(
  parameter int LATENCY   = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] width_in,
  input  logic [15:0] height_in,
  input  logic [3:0]  interlaced_in,
  input  logic        vip_ctrl_valid,
  input  logic        stall_in,
  input  logic        stall_out,
  input  logic        vip_ctrl_busy,
  output logic        read,
  output logic        write,
  output logic        pipe_en,
  output logic [15:0] width_out,
  output logic [15:0] height_out,
  output logic [3:0]  interlaced_out,
  output logic        vip_ctrl_send,
  output logic        end_of_video_out,
  output logic        frame_active
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_CTRL = 3'd2,
    S_STREAM    = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_s;
  logic [15:0]          width_r;
  logic [15:0]          height_r;
  logic [3:0]           interlaced_r;
  logic [CNT_WIDTH-1:0] total_r;
  logic [CNT_WIDTH-1:0] in_cnt_r;
  logic [CNT_WIDTH-1:0] out_cnt_r;
  logic [LATENCY-1:0]   vld_r;
  logic [LATENCY-1:0]   vld_shift_s;
  logic [31:0]          prod_s;
  logic [CNT_WIDTH-1:0] total_in_s;
  logic                 adv_s;
  logic                 piping_s;
  logic                 read_s;
  logic                 write_s;
  logic                 last_s;

  assign prod_s     = {16'd0, width_in} * {16'd0, height_in};
  assign total_in_s = CNT_WIDTH'(prod_s);

  // A stalled output only blocks the pipe when the last stage actually holds a pixel
  assign adv_s    = ~(vld_r[LATENCY-1] & stall_out);
  assign piping_s = (state_r == S_STREAM) || (state_r == S_DRAIN);
  assign read_s   = (state_r == S_STREAM) & adv_s & ~stall_in & (in_cnt_r < total_r);
  assign write_s  = piping_s & vld_r[LATENCY-1] & ~stall_out;
  assign last_s   = write_s & (out_cnt_r == (total_r - CNT_ONE));

  generate
    if (LATENCY == 1) begin : g_lat1
      assign vld_shift_s = read_s;
    end else begin : g_latn
      assign vld_shift_s = {vld_r[LATENCY-2:0], read_s};
    end
  endgenerate

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (vip_ctrl_valid && (total_in_s != '0)) state_s = S_SEND;
        else                                     state_s = S_IDLE;
      end
      S_SEND: state_s = S_WAIT_CTRL;
      S_WAIT_CTRL: begin
        if (!vip_ctrl_busy) state_s = S_STREAM;
        else                state_s = S_WAIT_CTRL;
      end
      S_STREAM: begin
        if (last_s)                     state_s = S_IDLE;
        else if (in_cnt_r == total_r)   state_s = S_DRAIN;
        else                            state_s = S_STREAM;
      end
      S_DRAIN: begin
        if (last_s) state_s = S_IDLE;
        else        state_s = S_DRAIN;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, latched geometry, pixel counters and pipeline occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      width_r      <= 16'd0;
      height_r     <= 16'd0;
      interlaced_r <= 4'd0;
      total_r      <= '0;
      in_cnt_r     <= '0;
      out_cnt_r    <= '0;
      vld_r        <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == S_IDLE) && vip_ctrl_valid) begin
        width_r      <= width_in;
        height_r     <= height_in;
        interlaced_r <= interlaced_in;
        total_r      <= total_in_s;
      end
      if ((state_s == S_SEND) && (state_r != S_SEND)) begin
        in_cnt_r  <= '0;
        out_cnt_r <= '0;
        vld_r     <= '0;
      end else begin
        if (read_s)          in_cnt_r  <= in_cnt_r + CNT_ONE;
        if (write_s)         out_cnt_r <= out_cnt_r + CNT_ONE;
        if (piping_s && adv_s) vld_r   <= vld_shift_s;
      end
    end
  end

  assign read             = read_s;
  assign write            = write_s;
  assign pipe_en          = piping_s & adv_s;
  assign end_of_video_out = last_s;
  assign vip_ctrl_send    = (state_r == S_SEND);
  assign frame_active     = (state_r != S_IDLE);
  assign width_out        = width_r;
  assign height_out       = height_r;
  assign interlaced_out   = interlaced_r;

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Directed bench for canny_frame_sequencer: per-cycle event log sampled on the falling
// edge, compared against hand-computed frame timing.
module tb_canny_frame_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] width_in;
  logic [15:0] height_in;
  logic [3:0]  interlaced_in;
  logic        vip_ctrl_valid;
  logic        stall_in;
  logic        stall_out;
  logic        vip_ctrl_busy;
  logic        read;
  logic        write;
  logic        pipe_en;
  logic [15:0] width_out;
  logic [15:0] height_out;
  logic [3:0]  interlaced_out;
  logic        vip_ctrl_send;
  logic        end_of_video_out;
  logic        frame_active;

  int n_chk, n_bad, cyc;
  int n_send, n_read, n_write, n_eov, n_active, n_hold, bad_stall, rd_busy;
  int send_cyc, first_read, last_read, first_write, last_write, eov_cyc, eov_wr_idx;

  canny_frame_sequencer #(.LATENCY(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .width_in(width_in), .height_in(height_in),
    .interlaced_in(interlaced_in), .vip_ctrl_valid(vip_ctrl_valid),
    .stall_in(stall_in), .stall_out(stall_out), .vip_ctrl_busy(vip_ctrl_busy),
    .read(read), .write(write), .pipe_en(pipe_en), .width_out(width_out),
    .height_out(height_out), .interlaced_out(interlaced_out),
    .vip_ctrl_send(vip_ctrl_send), .end_of_video_out(end_of_video_out),
    .frame_active(frame_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_send = 0; n_read = 0; n_write = 0; n_eov = 0; n_active = 0;
    n_hold = 0; bad_stall = 0; rd_busy = 0;
    send_cyc = -1; first_read = -1; last_read = -1; first_write = -1;
    last_write = -1; eov_cyc = -1; eov_wr_idx = -1;
  endtask

  // Sample one cycle on the falling edge, then step to just after the next rising edge
  task automatic tick();
    @(negedge clk);
    if (vip_ctrl_send) begin n_send++; send_cyc = cyc; end
    if (read) begin
      if (first_read < 0) first_read = cyc;
      last_read = cyc; n_read++;
      if (vip_ctrl_busy) rd_busy++;
    end
    if (write) begin
      if (first_write < 0) first_write = cyc;
      last_write = cyc; n_write++;
    end
    if (end_of_video_out) begin n_eov++; eov_cyc = cyc; eov_wr_idx = n_write; end
    if (frame_active) n_active++;
    if (stall_out) begin
      if (!pipe_en) n_hold++;
      if (read || write || pipe_en) bad_stall++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a control packet for one IDLE cycle; returns in the cycle after it
  task automatic start_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    clear_stats();
    width_in = w; height_in = h; interlaced_in = il; vip_ctrl_valid = 1'b1;
    tick();
    vip_ctrl_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check_val({tag, "_ctl"}, 32'({read, write, pipe_en, vip_ctrl_send, end_of_video_out, frame_active}), 32'd0);
    check_val({tag, "_geo"}, {width_out, height_out}, 32'd0);
    check_val({tag, "_il"}, 32'(interlaced_out), 32'd0);
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_bad = 0; cyc = 0;
    rst = 1'b0; width_in = 16'd0; height_in = 16'd0; interlaced_in = 4'd0;
    vip_ctrl_valid = 1'b0; stall_in = 1'b0; stall_out = 1'b0; vip_ctrl_busy = 1'b0;
    clear_stats();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_idle("reset");
    rst = 1'b1;
    ticks(2);

    // 1: 4x2, no stalls
    start_frame(16'd4, 16'd2, 4'hA);
    ticks(25);
    check_val("t1_send", n_send, 1);
    check_val("t1_rd_lat", first_read - send_cyc, 2);
    check_val("t1_reads", n_read, 8);
    check_val("t1_rd_span", last_read - first_read, 7);
    check_val("t1_writes", n_write, 8);
    check_val("t1_wr_lat", first_write - first_read, 4);
    check_val("t1_wr_span", last_write - first_write, 7);
    check_val("t1_eov_n", n_eov, 1);
    check_val("t1_eov_cyc", eov_cyc, last_write);
    check_val("t1_eov_idx", eov_wr_idx, 8);
    check_val("t1_geo", {width_out, height_out}, {16'd4, 16'd2});
    check_val("t1_il", 32'(interlaced_out), 32'd10);
    check_val("t1_active", 32'(frame_active), 32'd0);

    // 2: 4x2 with stall_out for 3 cycles while the pipe is full
    start_frame(16'd4, 16'd2, 4'h0);
    ticks(7);
    stall_out = 1'b1;
    ticks(3);
    stall_out = 1'b0;
    ticks(25);
    check_val("t2_hold", n_hold, 3);
    check_val("t2_bad_stall", bad_stall, 0);
    check_val("t2_reads", n_read, 8);
    check_val("t2_writes", n_write, 8);
    check_val("t2_eov_idx", eov_wr_idx, 8);
    check_val("t2_eov_n", n_eov, 1);

    // 3: 3x3 with stall_in toggling every cycle
    start_frame(16'd3, 16'd3, 4'h0);
    for (int i = 0; i < 40; i++) begin
      stall_in = ~stall_in;
      tick();
    end
    stall_in = 1'b0;
    ticks(5);
    check_val("t3_reads", n_read, 9);
    check_val("t3_writes", n_write, 9);
    check_val("t3_eov_idx", eov_wr_idx, 9);
    check_val("t3_out_cnt", dut.out_cnt_r, 9);
    check_val("t3_active", 32'(frame_active), 32'd0);

    // 4: zero-area frame, then a 1x1 frame
    start_frame(16'd0, 16'd5, 4'h0);
    ticks(10);
    check_val("t4_send", n_send, 0);
    check_val("t4_rw", n_read + n_write, 0);
    check_val("t4_active", n_active, 0);
    check_val("t4_height", 32'(height_out), 32'd5);
    start_frame(16'd1, 16'd1, 4'h3);
    ticks(12);
    check_val("t4b_send", n_send, 1);
    check_val("t4b_rw", {16'(n_read), 16'(n_write)}, {16'd1, 16'd1});
    check_val("t4b_wr_lat", first_write - first_read, 4);
    check_val("t4b_eov_n", n_eov, 1);

    // 5: busy held after send, mid-frame control pulse ignored
    vip_ctrl_busy = 1'b1;
    start_frame(16'd2, 16'd2, 4'h0);
    ticks(6);
    vip_ctrl_busy = 1'b0;
    ticks(2);
    width_in = 16'd9; vip_ctrl_valid = 1'b1;
    tick();
    vip_ctrl_valid = 1'b0; width_in = 16'd2;
    ticks(20);
    check_val("t5_rd_lat", first_read - send_cyc, 7);
    check_val("t5_rd_busy", rd_busy, 0);
    check_val("t5_width", 32'(width_out), 32'd2);
    check_val("t5_writes", n_write, 4);
    check_val("t5_eov_n", n_eov, 1);

    // 6: reset in DRAIN with two pixels still in flight
    start_frame(16'd4, 16'd2, 4'h5);
    ticks(11);
    rst = 1'b0;
    tick();
    check_val("t6_pre_writes", n_write, 6);
    check_val("t6_pre_eov", n_eov, 0);
    check_idle("t6_reset");
    rst = 1'b1;
    clear_stats();
    ticks(20);
    check_val("t6_writes", n_write, 0);
    check_val("t6_eov", n_eov, 0);
    check_val("t6_active", n_active, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
